// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller:
// opcodes, FSM state codes, opcode classes and ALU op codes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    // One-hot opcode class bit positions
    localparam int C_R    = 0;
    localparam int C_JR   = 1;
    localparam int C_BEQ  = 2;
    localparam int C_BNE  = 3;
    localparam int C_ADDI = 4;
    localparam int C_SLTI = 5;
    localparam int C_LUI  = 6;
    localparam int C_ORI  = 7;
    localparam int C_LW   = 8;
    localparam int C_SW   = 9;
    localparam int C_J    = 10;
    localparam int C_JAL  = 11;
    localparam int CLS_W  = 12;

    localparam logic [2:0] ALU_ADD = 3'b100;
    localparam logic [2:0] ALU_R   = 3'b010;
    localparam logic [2:0] ALU_BR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_LUI = 3'b110;
    localparam logic [2:0] ALU_ORI = 3'b111;

endpackage

// File: rtl/multicycle_ctrl_op_class.sv
// Combinational opcode classifier: one-hot class plus illegal flag.
// jr is split out of R-type by its funct field.
module op_class
    import ctrl_pkg::*;
#(
    parameter int EN_JAL = 1
) (
    input  logic [5:0]       op_i,
    input  logic [5:0]       funct_i,
    output logic [CLS_W-1:0] cls_o,
    output logic             illegal_o
);

    always_comb begin
        cls_o = '0;
        case (op_i)
            OP_R: begin
                if (funct_i == FN_JR) cls_o[C_JR] = 1'b1;
                else                  cls_o[C_R]  = 1'b1;
            end
            OP_BEQ:  cls_o[C_BEQ]  = 1'b1;
            OP_BNE:  cls_o[C_BNE]  = 1'b1;
            OP_ADDI: cls_o[C_ADDI] = 1'b1;
            OP_SLTI: cls_o[C_SLTI] = 1'b1;
            OP_LUI:  cls_o[C_LUI]  = 1'b1;
            OP_ORI:  cls_o[C_ORI]  = 1'b1;
            OP_LW:   cls_o[C_LW]   = 1'b1;
            OP_SW:   cls_o[C_SW]   = 1'b1;
            OP_J:    cls_o[C_J]    = 1'b1;
            OP_JAL:  cls_o[C_JAL]  = (EN_JAL != 0);
            default: cls_o = '0;
        endcase
        illegal_o = ~|cls_o;
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM (FETCH/DECODE/EXEC/MEM/WB)
// with retire pulse, illegal-opcode pulse and retired-instruction counter.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int ALUOP_W = 3,
    parameter int EN_JAL  = 1,
    parameter int CNT_W   = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [5:0]         instr_op_i,
    input  logic [5:0]         funct_i,
    input  logic               zero_i,
    input  logic               mem_ready_i,
    output logic               PCWrite_o,
    output logic               IRWrite_o,
    output logic               IorD_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               RegWrite_o,
    output logic               ALUSrcA_o,
    output logic [1:0]         PCSrc_o,
    output logic [1:0]         RegDst_o,
    output logic [1:0]         MemtoReg_o,
    output logic [1:0]         ALUSrcB_o,
    output logic [ALUOP_W-1:0] ALU_op_o,
    output logic [2:0]         state_o,
    output logic               done_o,
    output logic               illegal_o,
    output logic [CNT_W-1:0]   instr_cnt_o
);

    state_e             state_q, state_d;
    logic [5:0]         op_q, op_d;
    logic [5:0]         fn_q, fn_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               done_q, done_d;

    logic [5:0]         cls_op, cls_fn;
    logic [CLS_W-1:0]   cls;
    logic               cls_ill;

    logic       pc_wr, ir_wr, iord, mem_rd, mem_wr, reg_wr, src_a, ill;
    logic [1:0] pc_src, reg_dst, mtr, src_b;
    logic [2:0] alu;

    // DECODE classifies the live IR; later states use the latched copy
    assign cls_op = (state_q == S_DECODE) ? instr_op_i : op_q;
    assign cls_fn = (state_q == S_DECODE) ? funct_i    : fn_q;

    op_class #(.EN_JAL(EN_JAL)) u_op_class (
        .op_i      (cls_op),
        .funct_i   (cls_fn),
        .cls_o     (cls),
        .illegal_o (cls_ill)
    );

    always_comb begin
        state_d = S_FETCH;
        op_d    = op_q;
        fn_d    = fn_q;
        done_d  = 1'b0;
        ill     = 1'b0;
        pc_wr   = 1'b0;
        ir_wr   = 1'b0;
        iord    = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        reg_wr  = 1'b0;
        src_a   = 1'b0;
        pc_src  = 2'b00;
        reg_dst = 2'b00;
        mtr     = 2'b00;
        src_b   = 2'b00;
        alu     = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                mem_rd  = 1'b1;
                src_b   = 2'b01;
                pc_wr   = mem_ready_i;
                ir_wr   = mem_ready_i;
                state_d = mem_ready_i ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                op_d  = instr_op_i;
                fn_d  = funct_i;
                src_b = 2'b11;
                if (cls[C_J] || cls[C_JAL]) begin
                    pc_wr  = 1'b1;
                    pc_src = 2'b10;
                    done_d = 1'b1;
                    if (cls[C_JAL]) begin
                        reg_wr  = 1'b1;
                        reg_dst = 2'b10;
                        mtr     = 2'b10;
                    end
                end else if (cls[C_JR]) begin
                    pc_wr  = 1'b1;
                    pc_src = 2'b11;
                    done_d = 1'b1;
                end else if (cls_ill) begin
                    ill = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                src_a = 1'b1;
                unique case (1'b1)
                    cls[C_R]: begin
                        alu     = ALU_R;
                        state_d = S_WB;
                    end
                    cls[C_ADDI], cls[C_SLTI],
                    cls[C_LUI], cls[C_ORI]: begin
                        src_b   = 2'b10;
                        state_d = S_WB;
                        if (cls[C_SLTI]) alu = ALU_SLT;
                        if (cls[C_LUI])  alu = ALU_LUI;
                        if (cls[C_ORI])  alu = ALU_ORI;
                    end
                    cls[C_LW], cls[C_SW]: begin
                        src_b   = 2'b10;
                        state_d = S_MEM;
                    end
                    cls[C_BEQ], cls[C_BNE]: begin
                        alu    = ALU_BR;
                        pc_src = 2'b01;
                        pc_wr  = (cls[C_BEQ] & zero_i) | (cls[C_BNE] & ~zero_i);
                        done_d = 1'b1;
                    end
                    cls[C_J], cls[C_JAL], cls[C_JR], cls_ill: begin
                        state_d = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                iord = 1'b1;
                if (cls[C_LW]) begin
                    mem_rd  = 1'b1;
                    state_d = mem_ready_i ? S_WB : S_MEM;
                end else if (cls[C_SW]) begin
                    mem_wr  = 1'b1;
                    done_d  = mem_ready_i;
                    state_d = mem_ready_i ? S_FETCH : S_MEM;
                end
            end
            S_WB: begin
                reg_wr  = 1'b1;
                reg_dst = cls[C_R]  ? 2'b01 : 2'b00;
                mtr     = cls[C_LW] ? 2'b01 : 2'b00;
                done_d  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            fn_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            fn_q    <= fn_d;
            cnt_q   <= cnt_q + CNT_W'(done_d);
            done_q  <= done_d;
        end
    end

    // Reset masks every strobe immediately, not just after the edge
    assign PCWrite_o   = rst_i & pc_wr;
    assign IRWrite_o   = rst_i & ir_wr;
    assign IorD_o      = rst_i & iord;
    assign MemRead_o   = rst_i & mem_rd;
    assign MemWrite_o  = rst_i & mem_wr;
    assign RegWrite_o  = rst_i & reg_wr;
    assign ALUSrcA_o   = rst_i & src_a;
    assign PCSrc_o     = rst_i ? pc_src  : 2'b00;
    assign RegDst_o    = rst_i ? reg_dst : 2'b00;
    assign MemtoReg_o  = rst_i ? mtr     : 2'b00;
    assign ALUSrcB_o   = rst_i ? src_b   : 2'b00;
    assign ALU_op_o    = rst_i ? ALUOP_W'(alu) : '0;
    assign state_o     = state_q;
    assign done_o      = rst_i & done_q;
    assign illegal_o   = rst_i & ill;
    assign instr_cnt_o = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: default instance plus an
// EN_JAL=0 / CNT_W=4 / ALUOP_W=4 instance sharing the same inputs.
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, zero, rdy;
    logic [5:0] op, fn;

    logic       a_pcw, a_irw, a_iord, a_mrd, a_mwr, a_regw, a_srca;
    logic [1:0] a_pcsrc, a_regdst, a_mtr, a_srcb;
    logic [2:0] a_alu, a_state;
    logic       a_done, a_ill;
    logic [31:0] a_cnt;

    logic       b_pcw, b_irw, b_iord, b_mrd, b_mwr, b_regw, b_srca;
    logic [1:0] b_pcsrc, b_regdst, b_mtr, b_srcb;
    logic [3:0] b_alu;
    logic [2:0] b_state;
    logic       b_done, b_ill;
    logic [3:0] b_cnt;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int s = 0;

    multicycle_ctrl dut_a (
        .clk_i(clk), .rst_i(rst), .instr_op_i(op), .funct_i(fn),
        .zero_i(zero), .mem_ready_i(rdy),
        .PCWrite_o(a_pcw), .IRWrite_o(a_irw), .IorD_o(a_iord),
        .MemRead_o(a_mrd), .MemWrite_o(a_mwr), .RegWrite_o(a_regw),
        .ALUSrcA_o(a_srca), .PCSrc_o(a_pcsrc), .RegDst_o(a_regdst),
        .MemtoReg_o(a_mtr), .ALUSrcB_o(a_srcb), .ALU_op_o(a_alu),
        .state_o(a_state), .done_o(a_done), .illegal_o(a_ill),
        .instr_cnt_o(a_cnt)
    );

    multicycle_ctrl #(.ALUOP_W(4), .EN_JAL(0), .CNT_W(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .instr_op_i(op), .funct_i(fn),
        .zero_i(zero), .mem_ready_i(rdy),
        .PCWrite_o(b_pcw), .IRWrite_o(b_irw), .IorD_o(b_iord),
        .MemRead_o(b_mrd), .MemWrite_o(b_mwr), .RegWrite_o(b_regw),
        .ALUSrcA_o(b_srca), .PCSrc_o(b_pcsrc), .RegDst_o(b_regdst),
        .MemtoReg_o(b_mtr), .ALUSrcB_o(b_srcb), .ALU_op_o(b_alu),
        .state_o(b_state), .done_o(b_done), .illegal_o(b_ill),
        .instr_cnt_o(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; op = OP_R; fn = 6'b100000; zero = 1'b0; rdy = 1'b1;
        tick(); #1;
        chk("rst_state", a_state, 0);
        chk("rst_memrd", a_mrd, 0);
        chk("rst_pcw", a_pcw, 0);
        chk("rst_srcb", a_srcb, 0);
        chk("rst_alu", a_alu, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_done", a_done, 0);

        // add
        rst = 1'b1; #1;
        s = cyc;
        chk("add_f_state", a_state, 0);
        chk("add_f_memrd", a_mrd, 1);
        chk("add_f_irw", a_irw, 1);
        chk("add_f_pcw", a_pcw, 1);
        chk("add_f_srcb", a_srcb, 1);
        tick(); #1;
        chk("add_d_state", a_state, 1);
        chk("add_d_srcb", a_srcb, 3);
        chk("add_d_regw", a_regw, 0);
        tick(); op = OP_SW; #1;
        chk("add_e_state", a_state, 2);
        chk("add_e_srca", a_srca, 1);
        chk("add_e_srcb", a_srcb, 0);
        chk("add_e_alu", a_alu, 3'b010);
        tick(); #1;
        chk("add_w_state", a_state, 4);
        chk("add_w_regw", a_regw, 1);
        chk("add_w_regdst", a_regdst, 1);
        chk("add_w_mtr", a_mtr, 0);
        chk("add_w_done", a_done, 0);
        tick(); op = OP_LW; rdy = 1'b0; #1;
        chk("add_done", a_done, 1);
        chk("add_cnt", a_cnt, 1);
        chk("add_cnt_b", b_cnt, 1);
        chk("add_f2_regw", a_regw, 0);
        chk("add_lat", cyc - s, 4);

        // lw with fetch and memory waits
        s = cyc;
        chk("lw_f_pcw0", a_pcw, 0);
        chk("lw_f_memrd", a_mrd, 1);
        tick(); tick(); tick(); rdy = 1'b1; #1;
        chk("lw_f_pcw1", a_pcw, 1);
        tick(); #1;
        chk("lw_d_state", a_state, 1);
        tick(); #1;
        chk("lw_e_srcb", a_srcb, 2);
        chk("lw_e_alu", a_alu, 3'b100);
        tick(); rdy = 1'b0; #1;
        chk("lw_m_state", a_state, 3);
        chk("lw_m_memrd", a_mrd, 1);
        chk("lw_m_iord", a_iord, 1);
        tick(); #1;
        chk("lw_m2_state", a_state, 3);
        chk("lw_m2_memrd", a_mrd, 1);
        tick(); rdy = 1'b1; #1;
        chk("lw_m3_memrd", a_mrd, 1);
        tick(); #1;
        chk("lw_w_state", a_state, 4);
        chk("lw_w_mtr", a_mtr, 1);
        chk("lw_w_regdst", a_regdst, 0);
        chk("lw_w_regw", a_regw, 1);
        tick(); op = OP_BEQ; zero = 1'b1; #1;
        chk("lw_done", a_done, 1);
        chk("lw_cnt", a_cnt, 2);
        chk("lw_lat", cyc - s, 10);

        // beq taken
        s = cyc;
        tick(); tick(); #1;
        chk("beq_e_pcw", a_pcw, 1);
        chk("beq_e_pcsrc", a_pcsrc, 1);
        chk("beq_e_alu", a_alu, 3'b001);
        tick(); op = OP_BNE; #1;
        chk("beq_done", a_done, 1);
        chk("beq_cnt", a_cnt, 3);
        chk("beq_lat", cyc - s, 3);

        // bne not taken
        s = cyc;
        tick(); tick(); #1;
        chk("bne_e_state", a_state, 2);
        chk("bne_e_pcw", a_pcw, 0);
        chk("bne_e_pcsrc", a_pcsrc, 1);
        tick(); op = OP_J; zero = 1'b0; #1;
        chk("bne_done", a_done, 1);
        chk("bne_cnt", a_cnt, 4);
        chk("bne_lat", cyc - s, 3);

        // j
        s = cyc;
        tick(); #1;
        chk("j_d_pcw", a_pcw, 1);
        chk("j_d_pcsrc", a_pcsrc, 2);
        tick(); op = OP_JAL; #1;
        chk("j_done", a_done, 1);
        chk("j_cnt", a_cnt, 5);
        chk("j_lat", cyc - s, 2);

        // jal: legal on A, illegal on B
        tick(); #1;
        chk("jal_a_regw", a_regw, 1);
        chk("jal_a_regdst", a_regdst, 2);
        chk("jal_a_mtr", a_mtr, 2);
        chk("jal_a_pcw", a_pcw, 1);
        chk("jal_a_ill", a_ill, 0);
        chk("jal_b_ill", b_ill, 1);
        chk("jal_b_regw", b_regw, 0);
        chk("jal_b_pcw", b_pcw, 0);
        tick(); op = OP_R; fn = FN_JR; #1;
        chk("jal_a_cnt", a_cnt, 6);
        chk("jal_a_done", a_done, 1);
        chk("jal_b_cnt", b_cnt, 5);
        chk("jal_b_done", b_done, 0);
        chk("jal_b_state", b_state, 0);

        // jr
        tick(); #1;
        chk("jr_d_pcw", a_pcw, 1);
        chk("jr_d_pcsrc", a_pcsrc, 3);
        tick(); op = 6'b111111; #1;
        chk("jr_cnt", a_cnt, 7);

        // illegal opcode
        tick(); #1;
        chk("ill_pulse", a_ill, 1);
        chk("ill_pcw", a_pcw, 0);
        chk("ill_regw", a_regw, 0);
        chk("ill_mwr", a_mwr, 0);
        chk("ill_irw", a_irw, 0);
        tick(); op = OP_LUI; #1;
        chk("ill_done", a_done, 0);
        chk("ill_cnt", a_cnt, 7);
        chk("ill_state", a_state, 0);
        chk("ill_clear", a_ill, 0);

        // lui
        tick(); tick(); #1;
        chk("lui_e_alu", a_alu, 3'b110);
        chk("lui_e_alu_b", b_alu, 4'b0110);
        chk("lui_e_srcb", a_srcb, 2);
        tick(); #1;
        chk("lui_w_regw", a_regw, 1);
        chk("lui_w_regdst", a_regdst, 0);
        tick(); op = OP_SW; #1;
        chk("lui_cnt", a_cnt, 8);

        // sw aborted by reset during memory wait
        tick(); tick(); tick(); rdy = 1'b0; #1;
        chk("sw_m_state", a_state, 3);
        chk("sw_m_mwr", a_mwr, 1);
        chk("sw_m_iord", a_iord, 1);
        chk("sw_m_memrd", a_mrd, 0);
        tick(); #1;
        chk("sw_m2_mwr", a_mwr, 1);
        rst = 1'b0; #1;
        chk("sw_rst_mwr", a_mwr, 0);
        tick(); #1;
        chk("sw_rst_state", a_state, 0);
        chk("sw_rst_mwr2", a_mwr, 0);
        chk("sw_rst_cnt", a_cnt, 0);
        chk("sw_rst_cnt_b", b_cnt, 0);
        chk("sw_rst_done", a_done, 0);

        // 16 jumps: 4-bit counter wraps
        rst = 1'b1; op = OP_J; rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick(); tick(); #1;
            if (i == 14) chk("wrap_b15", b_cnt, 15);
        end
        chk("wrap_a16", a_cnt, 16);
        chk("wrap_b0", b_cnt, 0);
        chk("wrap_done", a_done, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter ALUOP_W, default 3, the ALU_op_o width (>=3; codes zero-extended).
REQ-002 The block SHALL have parameter EN_JAL, default 1; when 1 jal (000011) is legal, when 0 it is illegal.
REQ-003 The block SHALL have parameter CNT_W, default 32, the retired-instruction counter width.
REQ-004 The block SHALL have these ports: clk_i in 1 clock; rst_i in 1 reset; instr_op_i in 6 IR opcode; funct_i in 6 IR funct; zero_i in 1 ALU zero flag; mem_ready_i in 1 memory access complete.
REQ-005 The block SHALL have these ports: PCWrite_o, IRWrite_o, IorD_o, MemRead_o, MemWrite_o, RegWrite_o, ALUSrcA_o all out 1; PCSrc_o, RegDst_o, MemtoReg_o, ALUSrcB_o out 2; ALU_op_o out ALUOP_W.
REQ-006 The block SHALL have these ports: state_o out 3 current state; done_o out 1 retire pulse; illegal_o out 1 illegal-opcode pulse; instr_cnt_o out CNT_W retired count.
REQ-007 The block SHALL use one clock, clk_i; reset rst_i SHALL be synchronous and active-low.

Function
REQ-008 The controller SHALL be a Moore/Mealy FSM with states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL go to FETCH on the next edge.
REQ-009 Legal opcodes SHALL be R 000000, beq 000100, bne 000101, addi 001000, slti 001010, lui 001111, ori 001101, lw 100011, sw 101011, j 000010, jal per REQ-002; jr is R-type with funct 001000.
REQ-010 ALU_op_o codes SHALL be: add 100, R 010, branch 001, slti 101, lui 110, ori 111; all other states output add.
REQ-011 In FETCH: MemRead_o=1, IorD_o=0, ALUSrcA_o=0, ALUSrcB_o=01, PCSrc_o=00; PCWrite_o=IRWrite_o=mem_ready_i; go to DECODE when mem_ready_i=1, else hold.
REQ-012 In DECODE, opcode and funct SHALL be latched internally; EXEC, MEM and WB use only the latched copy. ALUSrcA_o=0 and ALUSrcB_o=11 SHALL be driven.
REQ-013 In DECODE, j SHALL drive PCWrite_o=1, PCSrc_o=10, then go to FETCH.
REQ-014 In DECODE, jal SHALL drive j signals plus RegWrite_o=1, RegDst_o=10 (r31), MemtoReg_o=10 (PC), then go to FETCH.
REQ-015 In DECODE, jr SHALL drive PCWrite_o=1, PCSrc_o=11, then go to FETCH.
REQ-016 In DECODE, an illegal opcode SHALL pulse illegal_o for one cycle with no write strobe, then go to FETCH; it is not counted as retired. All other opcodes SHALL go to EXEC.
REQ-017 In EXEC, ALUSrcA_o=1. R-type: ALUSrcB_o=00, go to WB. addi/slti/lui/ori: ALUSrcB_o=10, go to WB. lw/sw: ALUSrcB_o=10, add, go to MEM.
REQ-018 In EXEC for beq/bne: ALUSrcB_o=00, PCSrc_o=01, PCWrite_o=(beq&zero_i)|(bne&~zero_i), go to FETCH.
REQ-019 In MEM, IorD_o=1. lw: MemRead_o=1, go to WB on mem_ready_i. sw: MemWrite_o=1, go to FETCH on mem_ready_i. Otherwise hold with strobes steady.
REQ-020 In WB: RegWrite_o=1; RegDst_o=01 for R-type, else 00; MemtoReg_o=01 for lw, else 00; go to FETCH.
REQ-021 Any output not named for a state SHALL be 0.
REQ-022 done_o SHALL pulse on every legal transition into FETCH; instr_cnt_o SHALL increment in the same cycle, wrapping 2^CNT_W-1 to 0.
REQ-023 Instruction latency SHALL be: j/jal/jr 2 cycles, branch 3, R/I-ALU 4, sw 4, lw 5, plus the cycles each mem_ready_i wait adds.

Reset
REQ-024 While rst_i=0 at a clk_i edge: state FETCH, latched op/funct 0, instr_cnt_o 0, done_o/illegal_o 0.
REQ-025 While rst_i=0, all control outputs SHALL be forced 0; reset mid-instruction (including MEM wait) SHALL abort with no retire.

Structure
REQ-026 The shared package ctrl_pkg SHALL hold opcode/funct constants, the state encoding and ALU_op codes.
REQ-027 The combinational opcode classifier SHALL be a sub-module op_class (opcode, funct, EN_JAL -> one-hot class, illegal).

Verification
REQ-028 add, mem_ready_i always 1: state_o 0,1,2,4,0; RegWrite_o=1, RegDst_o=01 only in WB; done_o once; instr_cnt_o 0->1.
REQ-029 lw with FETCH ready delayed 3 cycles and MEM ready delayed 2 cycles: total 10 cycles; MemRead_o held steady; MemtoReg_o=01 in WB.
REQ-030 beq, zero_i=1: PCWrite_o=1 and PCSrc_o=01 in EXEC. bne, zero_i=1: PCWrite_o=0. Both retire after 3 cycles.
REQ-031 Opcode 111111: illegal_o pulses in DECODE, no write strobe, instr_cnt_o unchanged. Repeat with jal, EN_JAL=0: same result.
REQ-032 rst_i=0 during sw MEM wait: next cycle state_o=0, MemWrite_o=0, instr_cnt_o=0. CNT_W=4 with 16 retired: instr_cnt_o wraps to 0.
